// File: rtl/sync_high_pkg.sv
// ---------------------------------------------------------------------------
// sync_high_pkg
//   Shared constants and helpers for the sync_high synchronizer family.
//   MIN_STAGES   : shallowest flop chain that gives metastability time to settle
//   stages_valid : elaboration-time check of a requested chain depth
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
package sync_high_pkg;

  localparam int MIN_STAGES = 2;

  function automatic bit stages_valid(input int stages);
    return stages >= MIN_STAGES;
  endfunction

endpackage

// File: rtl/sync_high_chain.sv
// ---------------------------------------------------------------------------
// sync_high_chain
//   Single-bit synchronizer: STAGES flops in series, synchronous active-high
//   reset loads RESET_VAL into every flop.
//   Ports:
//     clk      : destination clock, rising edge
//     rst      : synchronous, active-high reset
//     async_in : asynchronous level, no timing relationship to clk
//     sync_out : last flop of the chain
//   Optional simulation model, enabled by defining
//   SYNC_HIGH_METASTABILITY_MODEL_EN: the first flop resolves X/Z inputs and
//   late input changes (last 1% of the clock period) to a random 0/1.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_high_chain
  import sync_high_pkg::*;
#(
  parameter int   STAGES    = MIN_STAGES,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic sync_out
);

  logic              stage1;
  logic [STAGES-1:1] stage_tail;

`ifdef SYNC_HIGH_METASTABILITY_MODEL_EN
  // Simulation-only capture model for the first flop.
  realtime last_change = 0.0;
  realtime last_edge   = 0.0;
  logic    prev_level  = 1'b0;
  logic    cur_level   = 1'b0;
  bit      seeded      = 1'b0;

  // FNV-1a hash of the instance path so each bit gets its own random stream.
  function automatic int unsigned path_seed(input string path);
    int unsigned h;
    h = 32'd2166136261;
    for (int i = 0; i < path.len(); i++) begin
      h = (h ^ {24'd0, path[i]}) * 32'd16777619;
    end
    return h;
  endfunction

  always @(async_in) begin
    prev_level  = cur_level;
    cur_level   = async_in;
    last_change = $realtime;
  end

  always @(posedge clk) begin
    realtime period;
    logic    pick;
    if (!seeded) begin
      void'($urandom(path_seed($sformatf("%m"))));
      seeded = 1'b1;
    end
    period = $realtime - last_edge;
    if (rst) begin
      stage1 <= RESET_VAL;
    end else if ($isunknown(async_in)) begin
      stage1 <= 1'($urandom_range(1, 0));
    end else if (last_edge > 0.0 && ($realtime - last_change) < 0.01 * period) begin
      pick = ($urandom_range(1, 0) != 0) ? cur_level : prev_level;
      if ($isunknown(pick)) pick = 1'($urandom_range(1, 0));
      stage1 <= pick;
    end else begin
      stage1 <= async_in;
    end
    last_edge = $realtime;
  end
`else
  // Capture stage: the only flop that ever sees the asynchronous input.
  always_ff @(posedge clk) begin
    if (rst) stage1 <= RESET_VAL;
    else     stage1 <= async_in;
  end
`endif

  // Settling stages: each extra flop gives metastability another period to resolve.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_tail <= {(STAGES-1){RESET_VAL}};
    end else begin
      stage_tail[1] <= stage1;
      for (int i = 2; i < STAGES; i++) begin
        stage_tail[i] <= stage_tail[i-1];
      end
    end
  end

  assign sync_out = stage_tail[STAGES-1];

endmodule

// File: rtl/sync_high.sv
// ---------------------------------------------------------------------------
// sync_high
//   WIDTH independent multi-flop synchronizers plus registered edge pulses of
//   the synchronized levels. Bits are not coherent with each other; buses
//   need gray coding or a handshake upstream.
//   Ports:
//     clk        : sole clock, rising edge
//     rst        : synchronous, active-high reset (all flops load RESET_VAL)
//     async_in   : [WIDTH] asynchronous input levels
//     sync_out   : [WIDTH] synchronized levels (last chain stage)
//     rise_pulse : [WIDTH] one cycle high when sync_out goes 0->1
//     fall_pulse : [WIDTH] one cycle high when sync_out goes 1->0
//   Optional macro SYNC_HIGH_METASTABILITY_MODEL_EN enables a simulation-only
//   random-resolution model in the capture flop of each chain.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module sync_high
  import sync_high_pkg::*;
#(
  parameter int   WIDTH     = 1,
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  if (!stages_valid(STAGES)) begin : g_bad_stages
    $error("sync_high: STAGES=%0d is below the minimum of %0d", STAGES, MIN_STAGES);
  end

  logic [WIDTH-1:0] sync_lvl;
  logic [WIDTH-1:0] prev_lvl;

  for (genvar b = 0; b < WIDTH; b++) begin : g_bit
    sync_high_chain #(
      .STAGES    (STAGES),
      .RESET_VAL (RESET_VAL)
    ) u_chain (
      .clk      (clk),
      .rst      (rst),
      .async_in (async_in[b]),
      .sync_out (sync_lvl[b])
    );
  end

  // Edge history: loading RESET_VAL on reset means a post-reset level equal
  // to RESET_VAL never produces a spurious pulse.
  always_ff @(posedge clk) begin
    if (rst) prev_lvl <= {WIDTH{RESET_VAL}};
    else     prev_lvl <= sync_lvl;
  end

  // Both operands are flop outputs, so the pulses change only at clock edges
  // and line up with the cycle in which sync_out takes its new value.
  assign sync_out   = sync_lvl;
  assign rise_pulse =  sync_lvl & ~prev_lvl;
  assign fall_pulse = ~sync_lvl &  prev_lvl;

endmodule

// File: tb/tb_sync_high.sv
// ---------------------------------------------------------------------------
// tb_sync_high
//   Scoreboard bench for sync_high. Two instances: the default configuration
//   (WIDTH=1, STAGES=2, RESET_VAL=0) and WIDTH=4, STAGES=3, RESET_VAL=1.
//   The stimulus process pushes one expectation per clock edge into a queue;
//   a monitor samples 1ns after every rising edge and pops/compares.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sync_high;

  logic tb_clk = 1'b0;
  always #5 tb_clk = ~tb_clk;

  logic       rst1, in1, s1, r1, f1;
  logic       rst4;
  logic [3:0] in4, s4, r4, f4;

  sync_high dut1 (
    .clk        (tb_clk),
    .rst        (rst1),
    .async_in   (in1),
    .sync_out   (s1),
    .rise_pulse (r1),
    .fall_pulse (f1)
  );

  sync_high #(
    .WIDTH     (4),
    .STAGES    (3),
    .RESET_VAL (1'b1)
  ) dut4 (
    .clk        (tb_clk),
    .rst        (rst4),
    .async_in   (in4),
    .sync_out   (s4),
    .rise_pulse (r4),
    .fall_pulse (f4)
  );

  typedef struct {
    string      name;
    bit         care_sync;
    bit         care_pulse;
    logic [3:0] sync;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t q1[$];
  exp_t q4[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic exp1(input string name, input bit cs, input bit cp,
                      input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.name = name; e.care_sync = cs; e.care_pulse = cp;
    e.sync = s; e.rise = r; e.fall = f;
    q1.push_back(e);
  endtask

  task automatic exp4(input string name, input bit cs, input bit cp,
                      input logic [3:0] s, input logic [3:0] r, input logic [3:0] f);
    exp_t e;
    e.name = name; e.care_sync = cs; e.care_pulse = cp;
    e.sync = s; e.rise = r; e.fall = f;
    q4.push_back(e);
  endtask

  task automatic cmp(input string name, input logic [3:0] act, input logic [3:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic score(input exp_t e, input logic [3:0] s, input logic [3:0] r,
                       input logic [3:0] f);
    checks++;
    if ($isunknown({s, r, f})) begin
      failures++;
      $display("FAIL %s.known: got sync=%b rise=%b fall=%b required all 0/1",
               e.name, s, r, f);
    end
    if (e.care_sync) cmp({e.name, ".sync"}, s, e.sync);
    if (e.care_pulse) begin
      cmp({e.name, ".rise"}, r, e.rise);
      cmp({e.name, ".fall"}, f, e.fall);
    end
  endtask

  // Monitor: sample away from the active edge and compare against the queue head.
  always @(posedge tb_clk) begin
    #1;
    if (q1.size() > 0) score(q1.pop_front(), {3'b000, s1}, {3'b000, r1}, {3'b000, f1});
    if (q4.size() > 0) score(q4.pop_front(), s4, r4, f4);
  end

  initial begin
    rst1 = 1'b1; in1 = 1'b1;
    rst4 = 1'b1; in4 = 4'h0;

    // Reset hold: input high is ignored while rst is asserted.
    for (int i = 0; i < 3; i++) begin
      exp1("rst_hold", 1, 1, 4'h0, 4'h0, 4'h0);
      @(posedge tb_clk);
    end

    // Release in the low phase; the level arrives two edges later.
    @(negedge tb_clk); rst1 = 1'b0;
    exp1("rel_e1", 1, 1, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("rel_e2", 1, 1, 4'h1, 4'h1, 4'h0); @(posedge tb_clk);
    exp1("rel_e3", 1, 1, 4'h1, 4'h0, 4'h0); @(posedge tb_clk);

    // Falling level.
    @(negedge tb_clk); in1 = 1'b0;
    exp1("fall_e1", 1, 1, 4'h1, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("fall_e2", 1, 1, 4'h0, 4'h0, 4'h1); @(posedge tb_clk);
    exp1("fall_e3", 1, 1, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);

    // Rising level.
    @(negedge tb_clk); in1 = 1'b1;
    exp1("rise_e1", 1, 1, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("rise_e2", 1, 1, 4'h1, 4'h1, 4'h0); @(posedge tb_clk);
    exp1("rise_e3", 1, 1, 4'h1, 4'h0, 4'h0); @(posedge tb_clk);

    // Glitch straddling an edge: low 0.095ns before, back high 0.05ns after.
    @(negedge tb_clk);
    exp1("glitch_k", 1, 1, 4'h1, 4'h0, 4'h0);
    #4.905 in1 = 1'b0;
    @(posedge tb_clk);
    #0.05 in1 = 1'b1;
    exp1("glitch_k1", 0, 0, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("glitch_k2", 1, 0, 4'h1, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("glitch_k3", 1, 1, 4'h1, 4'h0, 4'h0); @(posedge tb_clk);

    // Late transition 1->0 inside the setup window of edge k.
    @(negedge tb_clk);
    exp1("late_k", 1, 1, 4'h1, 4'h0, 4'h0);
    #4.905 in1 = 1'b0;
    @(posedge tb_clk);
    exp1("late_k1", 0, 0, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("late_k2", 1, 0, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("late_k3", 1, 1, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);

`ifdef SYNC_HIGH_METASTABILITY_MODEL_EN
    // Unknown input stream: outputs must always resolve to 0/1.
    for (int i = 0; i < 100; i++) begin
      @(negedge tb_clk); in1 = 1'bx;
      exp1("meta", 0, 0, 4'h0, 4'h0, 4'h0);
      @(posedge tb_clk);
    end
    @(negedge tb_clk); in1 = 1'b0;
    exp1("meta_rec1", 0, 0, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("meta_rec2", 0, 0, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("meta_rec3", 1, 0, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
    exp1("meta_rec4", 1, 1, 4'h0, 4'h0, 4'h0); @(posedge tb_clk);
`endif

    // Wide instance: reset value is all ones.
    @(negedge tb_clk);
    exp4("w_rst_a", 1, 1, 4'hF, 4'h0, 4'h0); @(posedge tb_clk);
    exp4("w_rst_b", 1, 1, 4'hF, 4'h0, 4'h0); @(posedge tb_clk);

    @(negedge tb_clk); rst4 = 1'b0; in4 = 4'h5;
    exp4("w5_e1", 1, 1, 4'hF, 4'h0, 4'h0); @(posedge tb_clk);
    exp4("w5_e2", 1, 1, 4'hF, 4'h0, 4'h0); @(posedge tb_clk);
    exp4("w5_e3", 1, 1, 4'h5, 4'h0, 4'hA); @(posedge tb_clk);
    exp4("w5_e4", 1, 1, 4'h5, 4'h0, 4'h0); @(posedge tb_clk);

    @(negedge tb_clk); in4 = 4'hA;
    exp4("wA_e1", 1, 1, 4'h5, 4'h0, 4'h0); @(posedge tb_clk);
    exp4("wA_e2", 1, 1, 4'h5, 4'h0, 4'h0); @(posedge tb_clk);
    exp4("wA_e3", 1, 1, 4'hA, 4'hA, 4'h5); @(posedge tb_clk);
    exp4("wA_e4", 1, 1, 4'hA, 4'h0, 4'h0); @(posedge tb_clk);

    // Reset in mid-operation reloads all ones with no pulses.
    @(negedge tb_clk); rst4 = 1'b1;
    exp4("w_rerst", 1, 1, 4'hF, 4'h0, 4'h0); @(posedge tb_clk);

    // Drain: every expectation must have been consumed by the monitor.
    @(posedge tb_clk);
    @(negedge tb_clk);
    checks++;
    if (q1.size() + q4.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending required 0", q1.size() + q4.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
